// File: rtl/tg_inject_arbiter_pkg.sv
// tg_inject_arbiter_pkg: flit layout shared by the injection arbiter and traffic generators
package tg_inject_arbiter_pkg;
    localparam int FLIT_WIDTH = 16;
    localparam int FLIT_HEAD_BIT = FLIT_WIDTH - 1;
    localparam int FLIT_TAIL_BIT = FLIT_WIDTH - 2;
    typedef logic [FLIT_WIDTH-1:0] flit_t;
    function automatic flit_t make_flit(logic head, logic tail, logic [FLIT_WIDTH-3:0] payload);
        return {head, tail, payload};
    endfunction
endpackage

// File: rtl/tg_inject_arbiter_if.sv
// tg_inject_arbiter_if: generator-side request/flit bundle and output FIFO write port
interface tg_inject_arbiter_if import tg_inject_arbiter_pkg::*; #(
    parameter int N_PORTS = 4,
    parameter int FLIT_WIDTH = tg_inject_arbiter_pkg::FLIT_WIDTH
);
    logic [N_PORTS-1:0] req;
    logic [N_PORTS-1:0] ready_in;
    logic [N_PORTS*FLIT_WIDTH-1:0] flit_in;
    logic [N_PORTS-1:0] obuf_full_out;
    logic obuf_full;
    logic [FLIT_WIDTH-1:0] flit_out;
    logic ready_out;
    modport master (output req, ready_in, flit_in, obuf_full, input obuf_full_out, flit_out, ready_out);
    modport slave (input req, ready_in, flit_in, obuf_full, output obuf_full_out, flit_out, ready_out);
endinterface

// File: rtl/tg_inject_arbiter_rr_next_requester.sv
// rr_next_requester: circular search for the next requester after ptr, ptr itself checked last
module rr_next_requester #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] next_ptr,
    output logic         any_req
);
    logic [2*N-1:0] dbl;
    logic [N-1:0] rot;
    always_comb begin
        dbl = {req, req};
        rot = N'(dbl >> (int'(ptr) + 1));
        next_ptr = ptr;
        for (int j = N - 1; j >= 0; j--)
            if (rot[j]) next_ptr = W'((int'(ptr) + 1 + j) % N);
        any_req = |req;
    end
endmodule

// File: rtl/tg_inject_arbiter.sv
// tg_inject_arbiter: round-robin packet-locked sharing of one output buffer among generators
module tg_inject_arbiter import tg_inject_arbiter_pkg::*; #(
    parameter int N_PORTS = 4,
    parameter int ID_WIDTH = 2,
    parameter int FLIT_WIDTH = tg_inject_arbiter_pkg::FLIT_WIDTH
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    tg_inject_arbiter_if.slave  bus,
    output logic [ID_WIDTH-1:0] grant_id,
    output logic                locked,
    output logic                err
);
    logic [ID_WIDTH-1:0] ptr, next_ptr;
    logic any_req, h, t, lock_nxt, adv;
    rr_next_requester #(.N(N_PORTS), .W(ID_WIDTH)) u_rr (
        .req(bus.req), .ptr(ptr), .next_ptr(next_ptr), .any_req(any_req)
    );
    assign grant_id = ptr;
    assign bus.flit_out = bus.flit_in[int'(ptr)*FLIT_WIDTH +: FLIT_WIDTH];
    assign bus.ready_out = bus.ready_in[ptr] & ~bus.obuf_full & enable & ~reset;
    assign h = bus.flit_out[FLIT_WIDTH-1];
    assign t = bus.flit_out[FLIT_WIDTH-2];
    always_comb begin
        for (int i = 0; i < N_PORTS; i++)
            bus.obuf_full_out[i] = reset | ~enable | bus.obuf_full | (ID_WIDTH'(i) != ptr);
        lock_nxt = locked ? ~(bus.ready_out & t) : (bus.ready_out & h & ~t);
        // a malformed inject never blocks rotation; only a clean head takes the lock
        adv = ~bus.obuf_full & (locked ? (bus.ready_out & t) : ~(bus.ready_out & h & ~t));
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
            locked <= 1'b0;
            err <= 1'b0;
        end else if (enable) begin
            err <= err | (bus.ready_out & (locked ? h : ~h));
            locked <= lock_nxt;
            if (adv & any_req) ptr <= next_ptr;
        end
    end
endmodule

// File: tb/tb_tg_inject_arbiter.sv
// tb_tg_inject_arbiter: scoreboarded random and directed checks against a packet-level model
module tb_tg_inject_arbiter;
    import tg_inject_arbiter_pkg::*;
    localparam int N = 4;
    typedef struct {
        bit rst;
        bit known;
        logic [N-1:0] obf;
        logic rdy;
        logic [15:0] flit;
        logic [1:0] gid;
        logic lk;
        logic er;
    } exp_t;
    logic clock = 0, reset = 1, enable = 0;
    logic [1:0] grant_id;
    logic locked, err;
    tg_inject_arbiter_if #(.N_PORTS(N), .FLIT_WIDTH(16)) bus ();
    tg_inject_arbiter #(.N_PORTS(N), .ID_WIDTH(2), .FLIT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .enable(enable), .bus(bus.slave),
        .grant_id(grant_id), .locked(locked), .err(err)
    );
    always #5 clock = ~clock;
    exp_t q[$];
    logic [15:0] gq[N][$];
    int checks = 0, failures = 0;
    int m_ptr = 0, last_wr = -1;
    bit m_locked = 0, m_err = 0, m_known = 0, rgate = 0;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
        end
    endtask
    initial forever begin
        @(negedge clock);
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("obuf_full_out", 32'(bus.obuf_full_out), 32'(e.obf));
            chk("ready_out", 32'(bus.ready_out), 32'(e.rdy));
            if (!e.rst && e.known) chk("flit_out", 32'(bus.flit_out), 32'(e.flit));
            if (e.known) begin
                chk("grant_id", 32'(grant_id), 32'(e.gid));
                chk("locked", 32'(locked), 32'(e.lk));
                chk("err", 32'(err), 32'(e.er));
            end
        end
    end
    task automatic add_pkt(input int p, input int len, input bit bad);
        for (int k = 0; k < len; k++)
            gq[p].push_back(make_flit((k == 0) ^ bad, k == len - 1, 14'($urandom)));
    endtask
    task automatic cycle(input bit rst, input bit en, input bit of, input logic [N-1:0] mask);
        exp_t e;
        logic [N-1:0] rq, rd;
        logic [15:0] fl[N];
        bit mv;
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            rd[i] = gq[i].size() > 0 && (!rgate || $urandom_range(3) != 0);
            rq[i] = mask[i] | (gq[i].size() > 0);
            fl[i] = gq[i].size() > 0 ? gq[i][0] : 16'($urandom);
            bus.flit_in[i*16 +: 16] = fl[i];
        end
        reset = rst;
        enable = en;
        bus.obuf_full = of;
        bus.req = rq;
        bus.ready_in = rd;
        e.rst = rst;
        e.known = m_known;
        e.rdy = !rst && en && !of && rd[m_ptr];
        e.obf = (rst || !en || of) ? 4'hF : ~(4'b1 << m_ptr);
        e.flit = fl[m_ptr];
        e.gid = 2'(m_ptr);
        e.lk = m_locked;
        e.er = m_err;
        q.push_back(e);
        last_wr = e.rdy ? m_ptr : -1;
        mv = 0;
        if (rst) begin
            m_ptr = 0;
            m_locked = 0;
            m_err = 0;
            m_known = 1;
            for (int i = 0; i < N; i++) gq[i].delete();
        end else if (en) begin
            if (e.rdy) begin
                void'(gq[m_ptr].pop_front());
                if (m_locked ? fl[m_ptr][15] : !fl[m_ptr][15]) m_err = 1;
            end
            if (!of) begin
                if (m_locked) begin
                    if (e.rdy && fl[m_ptr][14]) begin m_locked = 0; mv = 1; end
                end else if (e.rdy && fl[m_ptr][15] && !fl[m_ptr][14]) m_locked = 1;
                else mv = 1;
            end
            if (mv)
                for (int k = 1; k <= N; k++)
                    if (rq[(m_ptr + k) % N]) begin m_ptr = (m_ptr + k) % N; break; end
        end
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end
    initial begin
        int p1w, p3w, full_left;
        bit st;
        bus.req = 0;
        bus.ready_in = 0;
        bus.flit_in = 0;
        bus.obuf_full = 0;
        repeat (2) cycle(1, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin add_pkt(0, 1, 0); add_pkt(2, 1, 0); end
        repeat (10) cycle(0, 1, 0, 4'b0101);
        add_pkt(1, 5, 0);
        p1w = 0; st = 0; full_left = 0;
        for (int c = 0; c < 40; c++) begin
            bit of;
            of = full_left > 0;
            if (of) full_left--;
            cycle(0, 1, of, 4'b0111);
            if (last_wr == 1) p1w++;
            if (p1w == 2 && !st) begin st = 1; full_left = 3; end
        end
        repeat (10) cycle(0, 1, 0, 4'b0000);
        add_pkt((m_ptr + 1) % N, 1, 1);
        repeat (8) cycle(0, 1, 0, 4'b0000);
        cycle(1, 1, 0, 0);
        add_pkt(3, 5, 0);
        p3w = 0;
        for (int c = 0; c < 20 && p3w < 2; c++) begin
            cycle(0, 1, 0, 4'b1000);
            if (last_wr == 3) p3w++;
        end
        repeat (2) cycle(1, 1, 0, 0);
        repeat (3) cycle(0, 1, 0, 0);
        rgate = 1;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                if (gq[i].size() < 6 && $urandom_range(99) < 8)
                    add_pkt(i, $urandom_range(1, 4), $urandom_range(99) < 2);
            cycle($urandom_range(199) == 0, $urandom_range(9) != 0, $urandom_range(99) < 15,
                  4'($urandom) & 4'($urandom));
        end
        @(negedge clock);
        @(negedge clock);
        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tg_inject_arbiter.md
# tg_inject_arbiter

Round-robin injection scheduler that shares one node output buffer among `N_PORTS` Bernoulli traffic generators. It offers the buffer to exactly one generator per cycle by deasserting that generator's `obuf_full`. It muxes the winner's flit onto the single buffer write port and holds the grant for the whole packet, from head flit to tail flit. It sits between the per-node traffic-generator array and the node output FIFO.

## Interface
- `N_PORTS`, 4, number of traffic generators sharing the buffer (2..16)
- `ID_WIDTH`, 2, width of `grant_id`; must be ≥ ceil(log2(`N_PORTS`))
- `FLIT_WIDTH`, `` `FLIT_WIDTH ``, flit width; head bit at `FLIT_WIDTH-1`, tail bit at `FLIT_WIDTH-2`

Ports:
- `clock`  in  1  single clock domain
- `reset`  in  1  synchronous, active-high
- `enable`  in  1  global simulation enable, shared with the generators
- `req`  in  `N_PORTS`  per-port "has flit to try" (generator's try-inject term)
- `ready_in`  in  `N_PORTS`  per-port flit-valid from the generators
- `flit_in`  in  `N_PORTS*FLIT_WIDTH`  packed flits; port i at `[i*FLIT_WIDTH +: FLIT_WIDTH]`
- `obuf_full`  in  1  output FIFO full
- `obuf_full_out`  out  `N_PORTS`  per-port stall back to the generators
- `flit_out`  out  `FLIT_WIDTH`  flit to the output FIFO
- `ready_out`  out  1  FIFO write strobe
- `grant_id`  out  `ID_WIDTH`  current offered port (the `ptr` register)
- `locked`  out  1  mid-packet; grant frozen
- `err`  out  1  sticky protocol error

## Operation
- State: `ptr` (`ID_WIDTH`), `locked` (1), `err` (1).
- Offer: `obuf_full_out[i] = reset | ~enable | obuf_full | (i != ptr)`.
- Output: `flit_out = flit_in[ptr]`.
- Output: `ready_out = ready_in[ptr] & ~obuf_full & enable & ~reset`.
- Inject event = `ready_out`. Let `H`/`T` = head/tail bits of `flit_out`.
- Unlocked, inject with `H&~T`: set `locked`; `ptr` holds.
- Unlocked, inject with `H&T` (single-flit packet): `locked` stays 0; `ptr` advances.
- Locked, inject with `T`: clear `locked`; `ptr` advances.
- Locked, any other cycle (including body flits, `obuf_full`, idle generator): `ptr` holds.
- Unlocked, `obuf_full=0`, `enable=1`, no inject: `ptr` advances.
  - This covers a generator that ticked its RNG without injecting, or one with no request.
- Unlocked, `obuf_full=1`: `ptr` holds.
- Advance rule: new `ptr` = first port with `req` set, searching ptr+1, ptr+2, …, wrapping, with ptr itself last.
  - If no `req` is set, `ptr` holds.
- Error: inject with `~H` while unlocked, or with `H` while locked → `err` set.
  - `err` clears only on reset.
  - The flit is still written and the state update follows the rules above.
- `enable=0`: all state holds; all `obuf_full_out=1`; `ready_out=0`.

## Timing
- Reset values: `ptr=0`, `locked=0`, `err=0`.
- Outputs while `reset` is high: `obuf_full_out` all 1, `ready_out=0`, `grant_id=0`, `locked=0`, `err=0`.
- `flit_out` is undefined during reset (it tracks `flit_in[0]`).
- Zero-cycle combinational path `ready_in`/`obuf_full` → `ready_out`.
- `ptr`/`locked` update on `posedge clock`. A grant change is visible to generators the next cycle.
- Throughput: one flit per cycle while the owner streams and the FIFO is not full.
- Gap between packets: 0 cycles if the next-offered port injects immediately.
- Reset mid-packet: lock is dropped. The generators reset on the same `reset`, so no tail is pending afterwards.
- Simultaneous tail inject and `obuf_full` rising: `obuf_full` is sampled in the same cycle, so the tail is not written and the lock holds.

## Structure
- `` `FLIT_WIDTH ``, `` `FLIT_HEAD_BIT ``, `` `FLIT_TAIL_BIT `` live in `const.v`.
  - Add the head/tail macros there; the generator flit packing uses them too.
- Sub-module `rr_next_requester`: combinational, parameter `N`.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: `next_ptr`, `any_req`.
  - Circular priority search starting at `ptr+1`.

## Test plan
- `N_PORTS=4`, `req=4'b0101`, ports 0 and 2 send single-flit (H=T=1) packets every offer → `grant_id` sequence 0,2,0,2; `ready_out` every cycle; `err=0`.
- Port 1 sends a 5-flit packet while `req=4'b0111` → `locked=1` for 4 cycles after the head; `obuf_full_out=4'b1101` throughout; then `grant_id=2`.
- `obuf_full` high for 3 cycles after port 1's 2nd flit → `ready_out=0`, `ptr=1`, `locked=1` held; remaining 3 flits follow with no loss.
- `req=0`, `ready_in=0` for 10 cycles → `ptr` stays at its value; `ready_out=0`.
- Body flit (H=0, T=0) presented by the offered port while unlocked → written; `err=1` next cycle and stays 1 until reset.
- Reset asserted on the 3rd flit of a packet at `ptr=3` → next cycle `ptr=0`, `locked=0`, `err=0`, `obuf_full_out=4'b1111` while reset is high.
